// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: double-buffered digit data, per-digit dp/blank/blink
// masks, leading-zero suppression, active-low registered digit enables and segments.
module seg_scan_display #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 200000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    upd,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lzs,
   output logic [NUM_DIGITS-1:0]   led_en,
   output logic [7:0]              led_cx,
   output logic                    frame_tick
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

   typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'h0:    seg7 = 7'b0000001;
         4'h1:    seg7 = 7'b1001111;
         4'h2:    seg7 = 7'b0010010;
         4'h3:    seg7 = 7'b0000110;
         4'h4:    seg7 = 7'b1001100;
         4'h5:    seg7 = 7'b0100100;
         4'h6:    seg7 = 7'b0100000;
         4'h7:    seg7 = 7'b0001111;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0000100;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b1100000;
         4'hC:    seg7 = 7'b0110001;
         4'hD:    seg7 = 7'b1000010;
         4'hE:    seg7 = 7'b0110000;
         default: seg7 = 7'b0111000;
      endcase
   endfunction

   state_t                  state_q, state_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [FRM_W-1:0]        frm_q, frm_d;
   logic                    blink_on_q, blink_on_d;
   logic                    wrap_q;
   logic                    active, frame_wrap;

   logic [4*NUM_DIGITS-1:0] sh_dig_q, ds_dig_q;
   logic [NUM_DIGITS-1:0]   sh_dp_q, ds_dp_q;
   logic [NUM_DIGITS-1:0]   sh_blank_q, ds_blank_q;
   logic [NUM_DIGITS-1:0]   sh_blink_q, ds_blink_q;
   logic                    sh_lzs_q, ds_lzs_q;

   logic [NUM_DIGITS-1:0]   led_en_q, led_en_d;
   logic [7:0]              led_cx_q, led_cx_d;
   logic                    frame_tick_q;

   logic [NUM_DIGITS-1:0]   sup;
   logic                    all_zero;
   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_blank, cur_blink, cur_sup;

   // A stop pulse freezes the scan in its own cycle, so slot/index hold exactly where they were.
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      idx_d      = idx_q;
      frm_d      = frm_q;
      blink_on_d = blink_on_q;
      if (stop)       state_d = ST_STOP;
      else if (start) state_d = ST_RUN;
      active     = (state_q == ST_RUN) && !stop;
      frame_wrap = active && (slot_q == SLOT_LAST) && (idx_q == IDX_LAST);
      if (active) begin
         if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            slot_d = slot_q + 1'b1;
         end
      end
      if (frame_wrap) begin
         if (frm_q == FRM_LAST) begin
            frm_d      = '0;
            blink_on_d = !blink_on_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
   end

   // Suppression walks down from the top digit; digit 0 is never suppressed.
   always_comb begin
      all_zero  = 1'b1;
      sup       = '0;
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_blink = 1'b0;
      cur_sup   = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         all_zero = all_zero & (ds_dig_q[4*i +: 4] == 4'h0);
         sup[i]   = all_zero & ds_lzs_q;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib   = ds_dig_q[4*i +: 4];
            cur_dp    = ds_dp_q[i];
            cur_blank = ds_blank_q[i];
            cur_blink = ds_blink_q[i];
            cur_sup   = sup[i];
         end
      end
      led_en_d = active ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      if (!active || cur_blank || (cur_blink && !blink_on_q)) led_cx_d = 8'hFF;
      else if (cur_sup)                                       led_cx_d = {7'h7F, ~cur_dp};
      else                                                    led_cx_d = {seg7(cur_nib), ~cur_dp};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_STOP;
         slot_q       <= '0;
         idx_q        <= '0;
         frm_q        <= '0;
         blink_on_q   <= 1'b1;
         wrap_q       <= 1'b0;
         led_en_q     <= '1;
         led_cx_q     <= 8'hFF;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         idx_q        <= idx_d;
         frm_q        <= frm_d;
         blink_on_q   <= blink_on_d;
         wrap_q       <= frame_wrap;
         led_en_q     <= led_en_d;
         led_cx_q     <= led_cx_d;
         frame_tick_q <= wrap_q;
      end
   end

   // Display buffer loads from the shadow's old contents on the wrap edge, even if upd hits then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_dig_q   <= '0;
         sh_dp_q    <= '0;
         sh_blank_q <= '0;
         sh_blink_q <= '0;
         sh_lzs_q   <= 1'b0;
         ds_dig_q   <= '0;
         ds_dp_q    <= '0;
         ds_blank_q <= '0;
         ds_blink_q <= '0;
         ds_lzs_q   <= 1'b0;
      end else begin
         if (upd) begin
            sh_dig_q   <= digits;
            sh_dp_q    <= dp_mask;
            sh_blank_q <= blank_mask;
            sh_blink_q <= blink_mask;
            sh_lzs_q   <= lzs;
         end
         if (frame_wrap) begin
            ds_dig_q   <= sh_dig_q;
            ds_dp_q    <= sh_dp_q;
            ds_blank_q <= sh_blank_q;
            ds_blink_q <= sh_blink_q;
            ds_lzs_q   <= sh_lzs_q;
         end
      end
   end

   assign led_en     = led_en_q;
   assign led_cx     = led_cx_q;
   assign frame_tick = frame_tick_q;

endmodule
